// File: rtl/int_arb_pkg.sv
// Shared definitions for the interrupt arbiter: FSM encoding, register offsets, default sizes.
package int_arb_pkg;

    localparam int N_SRC_DEF = 6;
    localparam int ID_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_STATUS  = 2'd2;
    localparam logic [1:0] REG_EOI     = 2'd3;

endpackage

// File: rtl/int_arbiter_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of req, bit 0 highest priority.
module prio_enc #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    output logic         valid,
    output logic [W-1:0] id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = W'(i);
            end
        end
    end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter between device sources and the single CPU interrupt input.
// Define INT_ARB_LEVEL_EN for level-sensitive pending; default is edge capture with W1C.
module int_arbiter
    import int_arb_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_in,
    input  logic [1:0]       dev_addr,
    input  logic             dev_we,
    input  logic [31:0]      dev_wdata,
    output logic [31:0]      dev_rdata,
    output logic             int_request,
    input  logic             int_ack,
    output logic [N_SRC-1:0] hw_int
);

    // state   | meaning
    // IDLE    | nothing outstanding, waiting for pending & mask
    // REQ     | int_request high for source sel, waiting for int_ack
    // SERVICE | handler running for cur_id, waiting for EOI write

    state_t           state;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] active;
    logic [ID_W-1:0]  sel;
    logic [ID_W-1:0]  cur_id;
    logic [ID_W-1:0]  enc_id;
    logic             enc_valid;
    logic             wr_mask;
    logic             wr_eoi;
    logic             ack_take;
    logic             sel_live;

    wire unused_wdata = ^dev_wdata[31:N_SRC];

    assign active   = pending & mask;
    assign hw_int   = active;
    assign wr_mask  = dev_we && (dev_addr == REG_MASK);
    assign wr_eoi   = dev_we && (dev_addr == REG_EOI) && (state == ST_SERVICE);
    assign ack_take = (state == ST_REQ) && int_ack;
    assign sel_live = pending[sel] & mask[sel];

    prio_enc #(.N(N_SRC), .W(ID_W)) u_prio_enc (
        .req   (active),
        .valid (enc_valid),
        .id    (enc_id)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            mask <= '0;
        end else if (wr_mask) begin
            mask <= dev_wdata[N_SRC-1:0];
        end
    end

`ifdef INT_ARB_LEVEL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= irq_in;
        end
    end
`else
    logic [N_SRC-1:0] irq_d;
    logic [N_SRC-1:0] sel_onehot;
    logic [N_SRC-1:0] clr;
    logic             wr_pend;

    assign wr_pend    = dev_we && (dev_addr == REG_PENDING);
    assign sel_onehot = N_SRC'(1) << sel;
    // A new rising edge is OR-ed in after clearing, so it survives a same-cycle W1C or ack.
    assign clr        = (wr_pend ? dev_wdata[N_SRC-1:0] : '0) | (ack_take ? sel_onehot : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_d   <= '0;
            pending <= '0;
        end else begin
            irq_d   <= irq_in;
            pending <= (pending & ~clr) | (irq_in & ~irq_d);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            sel         <= '0;
            cur_id      <= '0;
            int_request <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enc_valid) begin
                        sel         <= enc_id;
                        int_request <= 1'b1;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    // Ack beats withdrawal: the CPU has already committed to the handler.
                    if (ack_take) begin
                        cur_id      <= sel;
                        int_request <= 1'b0;
                        state       <= ST_SERVICE;
                    end else if (!sel_live) begin
                        int_request <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (wr_eoi) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    int_request <= 1'b0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dev_rdata = '0;
        case (dev_addr)
            REG_MASK:    dev_rdata[N_SRC-1:0] = mask;
            REG_PENDING: dev_rdata[N_SRC-1:0] = pending;
            REG_STATUS: begin
                dev_rdata[9:8]      = state;
                dev_rdata[ID_W-1:0] = cur_id;
            end
            REG_EOI:     dev_rdata = '0;
        endcase
    end

endmodule
